// File: rtl/fir_sequencer.sv
// fir_sequencer: control sequencer for a FIR filter built from a circular sample
// buffer, a registered coefficient ROM and a multiply-accumulate unit.
module fir_sequencer #(
  parameter int DATA_WIDTH      = 48,
  parameter int NTAPS           = 256,
  parameter int COEF_ADDR_WIDTH = 8,
  parameter int MAC_LAT         = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_strobe,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic [DATA_WIDTH-1:0]      buf_data,
  output logic                       buf_wren,
  output logic                       buf_rden,
  output logic [COEF_ADDR_WIDTH-1:0] coef_addr,
  output logic                       mac_en,
  output logic                       mac_clr,
  output logic                       out_strobe,
  output logic                       busy,
  output logic                       overrun,
  output logic [15:0]                overrun_cnt
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [COEF_ADDR_WIDTH-1:0] LAST_TAP = COEF_ADDR_WIDTH'(NTAPS - 1);
  localparam logic [1:0]                 LAST_LAT = 2'(MAC_LAT - 1);

  state_t                     state, state_d;
  logic [COEF_ADDR_WIDTH-1:0] k, k_d;
  logic [1:0]                 lat_cnt, lat_cnt_d;
  logic [DATA_WIDTH-1:0]      buf_data_d;
  logic [COEF_ADDR_WIDTH-1:0] coef_addr_d;
  logic                       buf_wren_d, buf_rden_d, mac_en_d, mac_clr_d;
  logic                       out_strobe_d, busy_d, overrun_d;
  logic [15:0]                overrun_cnt_d;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d       = state;
    k_d           = k;
    lat_cnt_d     = lat_cnt;
    buf_data_d    = buf_data;
    coef_addr_d   = coef_addr;
    buf_wren_d    = 1'b0;
    buf_rden_d    = 1'b0;
    out_strobe_d  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (in_strobe) begin
          buf_data_d = in_data;
          buf_wren_d = 1'b1;
          state_d    = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d     = READ;
        k_d         = '0;
        buf_rden_d  = 1'b1;
        coef_addr_d = '0;
      end
      READ: begin
        if (k == LAST_TAP) begin
          state_d   = DRAIN;
          lat_cnt_d = '0;
        end else begin
          k_d         = k + 1'b1;
          buf_rden_d  = 1'b1;
          coef_addr_d = k + 1'b1;
        end
      end
      DRAIN: begin
        if (lat_cnt == LAST_LAT) begin
          state_d      = DONE;
          out_strobe_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // MAC operands arrive one cycle after the read; the first read of a pass is tap 0.
    mac_en_d  = buf_rden;
    mac_clr_d = buf_rden && (coef_addr == '0);

    busy_d    = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);

    // A strobe seen while busy is dropped; the pass in flight carries on untouched.
    overrun_d     = in_strobe && busy;
    overrun_cnt_d = overrun_cnt;
    if (overrun_d && (overrun_cnt != 16'hFFFF))
      overrun_cnt_d = overrun_cnt + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      lat_cnt     <= '0;
      buf_data    <= '0;
      buf_wren    <= 1'b0;
      buf_rden    <= 1'b0;
      coef_addr   <= '0;
      mac_en      <= 1'b0;
      mac_clr     <= 1'b0;
      out_strobe  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state       <= state_d;
      k           <= k_d;
      lat_cnt     <= lat_cnt_d;
      buf_data    <= buf_data_d;
      buf_wren    <= buf_wren_d;
      buf_rden    <= buf_rden_d;
      coef_addr   <= coef_addr_d;
      mac_en      <= mac_en_d;
      mac_clr     <= mac_clr_d;
      out_strobe  <= out_strobe_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
      overrun_cnt <= overrun_cnt_d;
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: buffer/ROM/MAC models around the DUT plus a scoreboard
// of golden convolution results; instance 2 exists only to saturate overrun_cnt.
`timescale 1ns/1ps
module tb_fir_sequencer;

  localparam int DW  = 48;
  localparam int CAW = 8;

  typedef struct {
    longint y;
    int     due;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset       [3];
  logic           in_strobe   [3];
  logic [DW-1:0]  in_data     [3];
  logic [DW-1:0]  buf_data    [3];
  logic           buf_wren    [3];
  logic           buf_rden    [3];
  logic [CAW-1:0] coef_addr   [3];
  logic           mac_en      [3];
  logic           mac_clr     [3];
  logic           out_strobe  [3];
  logic           busy        [3];
  logic           overrun     [3];
  logic [15:0]    overrun_cnt [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;
  int ovr_seen [2];

  exp_t   sb0 [$];
  exp_t   sb1 [$];
  longint hist0 [$];
  longint hist1 [$];
  exp_t   mon_e;
  bit     mon_have;

  // Models of the external buffer, registered ROM and MAC for instances 0 and 1.
  logic signed [DW-1:0] mem   [2][256];
  logic [7:0]           wptr  [2];
  logic [7:0]           rptr  [2];
  logic signed [DW-1:0] bdout [2];
  longint               rom_q [2];
  longint               acc   [2];
  longint               coef  [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fir_sequencer #(
      .DATA_WIDTH     (DW),
      .NTAPS          (g == 0 ? 4 : 256),
      .COEF_ADDR_WIDTH(CAW),
      .MAC_LAT        (g == 0 ? 1 : 2)
    ) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .in_strobe  (in_strobe[g]),
      .in_data    (in_data[g]),
      .buf_data   (buf_data[g]),
      .buf_wren   (buf_wren[g]),
      .buf_rden   (buf_rden[g]),
      .coef_addr  (coef_addr[g]),
      .mac_en     (mac_en[g]),
      .mac_clr    (mac_clr[g]),
      .out_strobe (out_strobe[g]),
      .busy       (busy[g]),
      .overrun    (overrun[g]),
      .overrun_cnt(overrun_cnt[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset[i]) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        bdout[i] <= '0;
        acc[i]   <= 0;
        for (int a = 0; a < 256; a++) mem[i][a] <= '0;
      end else begin
        if (buf_wren[i]) begin
          mem[i][wptr[i]] <= buf_data[i];
          rptr[i]         <= wptr[i];
          wptr[i]         <= wptr[i] + 8'd1;
        end else if (buf_rden[i]) begin
          bdout[i] <= mem[i][rptr[i]];
          rptr[i]  <= rptr[i] - 8'd1;
        end
        if (mac_en[i])
          acc[i] <= (mac_clr[i] ? 64'sd0 : acc[i]) + longint'(bdout[i]) * rom_q[i];
      end
      rom_q[i] <= coef[i][coef_addr[i]];
    end
  end

  // Scoreboard: every out_strobe pops one expectation (value and cycle).
  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < 2; i++) begin
        if (overrun[i]) ovr_seen[i]++;
        checks++;
        if (buf_wren[i] && buf_rden[i]) begin
          errors++;
          $display("FAIL wren_rden_overlap dut%0d cycle=%0d", i, cyc);
        end
        if (out_strobe[i]) begin
          mon_have = 1'b0;
          if (i == 0 && sb0.size() > 0) begin mon_e = sb0.pop_front(); mon_have = 1'b1; end
          if (i == 1 && sb1.size() > 0) begin mon_e = sb1.pop_front(); mon_have = 1'b1; end
          checks++;
          if (!mon_have) begin
            errors++;
            $display("FAIL unexpected_out_strobe dut%0d cycle=%0d acc=%0d", i, cyc, acc[i]);
          end else if (acc[i] !== mon_e.y || cyc !== mon_e.due) begin
            errors++;
            $display("FAIL out_value dut%0d got=%0d@%0d want=%0d@%0d",
                     i, acc[i], cyc, mon_e.y, mon_e.due);
          end
        end
      end
    end
  end

  function automatic int ntaps(input int i);
    return (i == 0) ? 4 : 256;
  endfunction

  function automatic int out_lat(input int i);
    return (i == 0) ? 7 : 260;
  endfunction

  // y[n] = sum h[k]*x[n-k], with x before the first post-reset sample taken as 0.
  function automatic longint golden(input int i, input longint x);
    longint y;
    int     n;
    y = coef[i][0] * x;
    n = (i == 0) ? hist0.size() : hist1.size();
    for (int k = 1; k < ntaps(i); k++)
      if (n - k >= 0)
        y += coef[i][k] * ((i == 0) ? hist0[n - k] : hist1[n - k]);
    return y;
  endfunction

  function automatic logic [DW+CAW+22:0] outs(input int i);
    return {buf_data[i], buf_wren[i], buf_rden[i], coef_addr[i], mac_en[i], mac_clr[i],
            out_strobe[i], busy[i], overrun[i], overrun_cnt[i]};
  endfunction

  // Called at a negedge; drives one strobe cycle and returns at the next negedge.
  task automatic send(input int i, input longint x, input bit accept, input longint y);
    exp_t e;
    in_strobe[i] = 1'b1;
    in_data[i]   = x[DW-1:0];
    if (accept) begin
      e.y   = y;
      e.due = cyc + out_lat(i);
      if (i == 0) begin sb0.push_back(e); hist0.push_back(x); end
      else        begin sb1.push_back(e); hist1.push_back(x); end
    end
    @(negedge clk);
    in_strobe[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i);
    int n = 0;
    while (((i == 0) ? sb0.size() : sb1.size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout dut%0d pending=%0d", i, (i == 0) ? sb0.size() : sb1.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset[i]     = 1'b1;
      in_strobe[i] = 1'b0;
      in_data[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs(i) !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got=%h want=0", i, outs(i));
      end
      reset[i] = 1'b0;
    end
    @(negedge clk);
    mon_on = 1'b1;
  endtask

  task automatic test_impulse();
    longint xs [5] = '{1, 0, 0, 0, 0};
    longint ys [5] = '{1, 2, 3, 4, 0};
    for (int k = 0; k < 4; k++) coef[0][k] = k + 1;
    for (int s = 0; s < 5; s++) begin
      send(0, xs[s], 1'b1, ys[s]);
      repeat (6) @(negedge clk);
    end
    wait_drain(0);
  endtask

  task automatic test_strobe_trace();
    logic [5:0] got, want;
    send(0, 5, 1'b1, golden(0, 5));
    for (int t = 1; t <= 7; t++) begin
      got  = {buf_wren[0], buf_rden[0], mac_en[0], mac_clr[0], busy[0], out_strobe[0]};
      want = {t == 1, t >= 2 && t <= 5, t >= 3 && t <= 6, t == 3, t <= 6, t == 7};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL trace_strobes t=%0d got=%b want=%b", t, got, want);
      end
      if (t >= 2 && t <= 5) begin
        checks++;
        if (coef_addr[0] !== CAW'(t - 2)) begin
          errors++;
          $display("FAIL trace_coef_addr t=%0d got=%0d want=%0d", t, coef_addr[0], t - 2);
        end
      end
      @(negedge clk);
    end
    wait_drain(0);
  endtask

  task automatic test_back_to_back();
    int     ov0 = ovr_seen[0];
    longint x;
    for (int s = 0; s < 300; s++) begin
      x = longint'($urandom_range(2000)) - 1000;
      send(0, x, 1'b1, golden(0, x));
      repeat (6) @(negedge clk);
    end
    wait_drain(0);
    checks++;
    if (ovr_seen[0] !== ov0 || overrun_cnt[0] !== 16'd0) begin
      errors++;
      $display("FAIL b2b_no_overrun pulses=%0d cnt=%0d want 0", ovr_seen[0] - ov0, overrun_cnt[0]);
    end
  endtask

  task automatic test_overrun();
    send(0, 7, 1'b1, golden(0, 7));
    repeat (2) @(negedge clk);
    send(0, 99, 1'b0, 0);
    checks++;
    if (overrun[0] !== 1'b1 || overrun_cnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL overrun_pulse got=%b cnt=%0d want=1 cnt=1", overrun[0], overrun_cnt[0]);
    end
    @(negedge clk);
    checks++;
    if (overrun[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_one_cycle overrun=%b busy=%b want 0 1", overrun[0], busy[0]);
    end
    wait_drain(0);
  endtask

  task automatic test_reset_mid_read();
    int stale = 0;
    in_strobe[0] = 1'b1;
    in_data[0]   = 48'd1;
    @(negedge clk);
    in_strobe[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    hist0.delete();
    checks++;
    if (outs(0) !== '0) begin
      errors++;
      $display("FAIL reset_mid_read_outputs got=%h want=0", outs(0));
    end
    repeat (12) begin
      @(negedge clk);
      if (out_strobe[0]) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL stale_out_strobe got=%0d want=0", stale);
    end
    send(0, 3, 1'b1, 3);
    repeat (6) @(negedge clk);
    send(0, 0, 1'b1, 6);
    wait_drain(0);
  endtask

  task automatic test_default_random();
    longint x;
    for (int k = 0; k < 256; k++) coef[1][k] = longint'($signed(16'($urandom())));
    for (int s = 0; s < 50; s++) begin
      x = longint'($signed(16'($urandom())));
      send(1, x, 1'b1, golden(1, x));
      repeat (259) @(negedge clk);
    end
    wait_drain(1);
  endtask

  // in_strobe held high: one accept per 260-cycle pass, 259 drops in between.
  task automatic test_overrun_saturation();
    in_data[2]   = '0;
    in_strobe[2] = 1'b1;
    repeat (260) @(negedge clk);
    checks++;
    if (overrun_cnt[2] !== 16'd259) begin
      errors++;
      $display("FAIL overrun_count_one_pass got=%0d want=259", overrun_cnt[2]);
    end
    repeat (70300 - 260) @(negedge clk);
    in_strobe[2] = 1'b0;
    checks++;
    if (overrun_cnt[2] !== 16'hFFFF) begin
      errors++;
      $display("FAIL overrun_saturate got=%h want=ffff", overrun_cnt[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ovr_seen[i] = 0;
      for (int k = 0; k < 256; k++) coef[i][k] = 0;
    end
    @(negedge clk);
    test_reset();
    fork
      begin
        test_impulse();
        test_strobe_trace();
        test_back_to_back();
        test_overrun();
        test_reset_mid_read();
        test_default_random();
      end
      test_overrun_saturation();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
